// File: rtl/led_strip_pkg.sv
// Shared definitions for the APA102-style LED strip frame sequencer.
// Holds frame-level constants, state encodings for the frame sequencer and
// the byte handshake, and the end-frame length helper.
package led_strip_pkg;

  localparam int          START_FRAME_BYTES = 4;
  localparam int          BRIGHT_W          = 5;
  localparam logic [2:0]  HDR_BITS          = 3'b111;
  localparam logic [7:0]  START_BYTE        = 8'h00;
  localparam logic [7:0]  END_BYTE          = 8'hFF;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SEND_START,
    ST_PIX_ADDR,
    ST_PIX_LATCH,
    ST_SEND_PIX,
    ST_NEXT_LED,
    ST_SEND_END,
    ST_DONE
  } frame_state_e;

  typedef enum logic [1:0] {
    HS_IDLE,
    HS_ISSUE,
    HS_WAIT_HI,
    HS_WAIT_LO
  } hs_state_e;

  // The end frame needs at least half a clock edge per LED to push data
  // through the whole strip, with a floor of four bytes.
  function automatic int calc_end_bytes(input int num_leds);
    int n;
    n = (num_leds + 15) / 16;
    return (n > 4) ? n : 4;
  endfunction

endpackage

// File: rtl/led_strip_frame_if.sv
// Bundle of the frame sequencer's external signals: frame request/status,
// pixel RAM read port and the byte handshake toward the SPI byte writer.
//   master : the frame sequencer (drives byte_start/byte_data, pixel_addr,
//            frame_busy/frame_done)
//   slave  : the environment (pattern logic, pixel RAM, SPI writer)
interface led_strip_frame_if
  import led_strip_pkg::*;
#(
  parameter int ADDR_WIDTH = 6
) ();

  logic                  frame_start;
  logic                  frame_busy;
  logic                  frame_done;
  logic [BRIGHT_W-1:0]   brightness;
  logic [ADDR_WIDTH-1:0] pixel_addr;
  logic [23:0]           pixel_data;
  logic                  byte_start;
  logic [7:0]            byte_data;
  logic                  byte_busy;

  modport master (
    input  frame_start,
    input  brightness,
    input  pixel_data,
    input  byte_busy,
    output frame_busy,
    output frame_done,
    output pixel_addr,
    output byte_start,
    output byte_data
  );

  modport slave (
    output frame_start,
    output brightness,
    output pixel_data,
    output byte_busy,
    input  frame_busy,
    input  frame_done,
    input  pixel_addr,
    input  byte_start,
    input  byte_data
  );

endinterface

// File: rtl/led_byte_handshake.sv
// One-byte start/busy handshake toward the SPI byte writer.
// A load pulse (accepted only while idle) captures load_data, raises
// byte_start for one cycle, waits for byte_busy to rise and then fall, and
// reports completion with a one-cycle byte_ack.
// Ports:
//   strip_clk, strip_reset : clock, synchronous active-high reset
//   load, load_data        : request to send one byte
//   byte_busy              : writer busy
//   byte_start, byte_data  : to the writer; byte_data held until the next load
//   byte_ack               : pulse after the writer finished the byte
module led_byte_handshake
  import led_strip_pkg::*;
(
  input  logic       strip_clk,
  input  logic       strip_reset,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       byte_busy,
  output logic       byte_start,
  output logic [7:0] byte_data,
  output logic       byte_ack
);

  hs_state_e state;

  always_ff @(posedge strip_clk) begin
    if (strip_reset) begin
      state      <= HS_IDLE;
      byte_start <= 1'b0;
      byte_data  <= 8'h00;
      byte_ack   <= 1'b0;
    end else begin
      byte_start <= 1'b0;
      byte_ack   <= 1'b0;
      unique case (state)
        HS_IDLE: begin
          if (load) begin
            byte_data  <= load_data;
            byte_start <= 1'b1;
            state      <= HS_ISSUE;
          end
        end
        // byte_start is high during this cycle; the writer answers with busy
        // on the following one.
        HS_ISSUE:   state <= HS_WAIT_HI;
        HS_WAIT_HI: if (byte_busy) state <= HS_WAIT_LO;
        HS_WAIT_LO: begin
          if (!byte_busy) begin
            byte_ack <= 1'b1;
            state    <= HS_IDLE;
          end
        end
        default: state <= HS_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/led_strip_frame.sv
// APA102-style LED strip frame sequencer.
// On an accepted frame_start it emits, byte by byte through the SPI writer
// handshake: four 0x00 start bytes, then {111,brightness}, blue, green, red
// for every LED (colours read from a 1-cycle-latency pixel RAM), then
// END_BYTES bytes of 0xFF, and finally pulses frame_done.
// Ports:
//   strip_clk, strip_reset : clock, synchronous active-high reset
//   strip (master)         : frame request/status, pixel RAM read port,
//                            byte_start/byte_data/byte_busy to the writer
module led_strip_frame
  import led_strip_pkg::*;
#(
  parameter int NUM_LEDS   = 60,
  parameter int ADDR_WIDTH = 6
) (
  input  logic              strip_clk,
  input  logic              strip_reset,
  led_strip_frame_if.master strip
);

  localparam int                    END_BYTES = calc_end_bytes(NUM_LEDS);
  localparam logic [ADDR_WIDTH-1:0] LAST_LED  = ADDR_WIDTH'(NUM_LEDS - 1);
  localparam logic [7:0]            END_LAST  = 8'(END_BYTES - 1);
  localparam logic [1:0]            START_LAST = 2'(START_FRAME_BYTES - 1);

  if (NUM_LEDS < 1 || NUM_LEDS > 1023 || (2 ** ADDR_WIDTH) < NUM_LEDS) begin : g_param_check
    $error("led_strip_frame: NUM_LEDS out of range for ADDR_WIDTH");
  end

  frame_state_e          state;
  logic                  frame_busy_q;
  logic                  frame_done_q;
  logic [BRIGHT_W-1:0]   bright_q;
  logic [ADDR_WIDTH-1:0] pixel_addr_q;
  logic [ADDR_WIDTH-1:0] led_index;
  logic [23:0]           pix_q;
  logic [1:0]            grp_cnt;
  logic [7:0]            end_cnt;
  logic                  hs_load;
  logic [7:0]            hs_data;
  logic                  hs_pending;
  logic                  hs_ack;
  logic [7:0]            cur_byte;

  assign strip.frame_busy = frame_busy_q;
  assign strip.frame_done = frame_done_q;
  assign strip.pixel_addr = pixel_addr_q;

  // Byte to send next in the current sending state.
  always_comb begin
    cur_byte = START_BYTE;
    case (state)
      ST_SEND_PIX: begin
        case (grp_cnt)
          2'd0:    cur_byte = {HDR_BITS, bright_q};
          2'd1:    cur_byte = pix_q[7:0];
          2'd2:    cur_byte = pix_q[15:8];
          default: cur_byte = pix_q[23:16];
        endcase
      end
      ST_SEND_END: cur_byte = END_BYTE;
      default:     cur_byte = START_BYTE;
    endcase
  end

  // In every sending state the first cycle hands the byte to the handshake
  // (hs_pending marks it in flight); byte_ack then advances the counters.
  always_ff @(posedge strip_clk) begin
    if (strip_reset) begin
      state        <= ST_IDLE;
      frame_busy_q <= 1'b0;
      frame_done_q <= 1'b0;
      bright_q     <= '0;
      pixel_addr_q <= '0;
      led_index    <= '0;
      pix_q        <= '0;
      grp_cnt      <= '0;
      end_cnt      <= '0;
      hs_load      <= 1'b0;
      hs_data      <= '0;
      hs_pending   <= 1'b0;
    end else begin
      hs_load      <= 1'b0;
      frame_done_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (strip.frame_start) begin
            bright_q     <= strip.brightness;
            frame_busy_q <= 1'b1;
            grp_cnt      <= '0;
            hs_pending   <= 1'b0;
            state        <= ST_SEND_START;
          end
        end
        ST_SEND_START, ST_SEND_PIX, ST_SEND_END: begin
          if (!hs_pending) begin
            hs_load    <= 1'b1;
            hs_data    <= cur_byte;
            hs_pending <= 1'b1;
          end else if (hs_ack) begin
            hs_pending <= 1'b0;
            if (state == ST_SEND_START) begin
              grp_cnt <= grp_cnt + 2'd1;
              if (grp_cnt == START_LAST) begin
                // Address goes out on entry so the RAM word is ready in PIX_LATCH.
                pixel_addr_q <= led_index;
                state        <= ST_PIX_ADDR;
              end
            end else if (state == ST_SEND_PIX) begin
              grp_cnt <= grp_cnt + 2'd1;
              if (grp_cnt == 2'd3) state <= ST_NEXT_LED;
            end else begin
              if (end_cnt == END_LAST) begin
                end_cnt      <= '0;
                frame_done_q <= 1'b1;
                frame_busy_q <= 1'b0;
                state        <= ST_DONE;
              end else begin
                end_cnt <= end_cnt + 8'd1;
              end
            end
          end
        end
        ST_PIX_ADDR:  state <= ST_PIX_LATCH;
        ST_PIX_LATCH: begin
          pix_q   <= strip.pixel_data;
          grp_cnt <= '0;
          state   <= ST_SEND_PIX;
        end
        ST_NEXT_LED: begin
          if (led_index == LAST_LED) begin
            led_index <= '0;
            end_cnt   <= '0;
            state     <= ST_SEND_END;
          end else begin
            led_index    <= led_index + 1'b1;
            pixel_addr_q <= led_index + 1'b1;
            state        <= ST_PIX_ADDR;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  led_byte_handshake u_hs (
    .strip_clk   (strip_clk),
    .strip_reset (strip_reset),
    .load        (hs_load),
    .load_data   (hs_data),
    .byte_busy   (strip.byte_busy),
    .byte_start  (strip.byte_start),
    .byte_data   (strip.byte_data),
    .byte_ack    (hs_ack)
  );

endmodule

// File: tb/tb_led_strip_frame.sv
module tb_led_strip_frame;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  led_strip_frame_if #(.ADDR_WIDTH(6)) s0 ();
  led_strip_frame_if #(.ADDR_WIDTH(6)) s1 ();
  led_strip_frame_if #(.ADDR_WIDTH(7)) s2 ();

  led_strip_frame #(.NUM_LEDS(2),   .ADDR_WIDTH(6)) dut0 (.strip_clk(clk), .strip_reset(rst), .strip(s0));
  led_strip_frame #(.NUM_LEDS(40),  .ADDR_WIDTH(6)) dut1 (.strip_clk(clk), .strip_reset(rst), .strip(s1));
  led_strip_frame #(.NUM_LEDS(100), .ADDR_WIDTH(7)) dut2 (.strip_clk(clk), .strip_reset(rst), .strip(s2));

  typedef struct {
    logic [4:0]   bright;
    logic [4:0]   bright_mid;
    int           busy_len;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [4];

  int n_chk = 0;
  int n_err = 0;
  int busy_len0 = 3;

  function automatic logic [23:0] ram_word(input logic [7:0] i);
    return {i, i ^ 8'h5A, 8'hFF - i};
  endfunction

  // Pixel RAMs, 1-cycle read latency
  always @(posedge clk) begin
    s0.pixel_data <= (s0.pixel_addr == 6'd0) ? 24'h112233 :
                     (s0.pixel_addr == 6'd1) ? 24'hAABBCC : 24'h000000;
    s1.pixel_data <= ram_word({2'b00, s1.pixel_addr});
    s2.pixel_data <= ram_word({1'b0, s2.pixel_addr});
  end

  // Behavioural SPI writers: busy rises the cycle after start, held busy_len cycles
  int wc0, wc1, wc2;
  always @(posedge clk) begin
    if (rst) begin
      s0.byte_busy <= 1'b0; s1.byte_busy <= 1'b0; s2.byte_busy <= 1'b0;
      wc0 <= 0; wc1 <= 0; wc2 <= 0;
    end else begin
      if (!s0.byte_busy && s0.byte_start) begin s0.byte_busy <= 1'b1; wc0 <= busy_len0 - 1; end
      else if (s0.byte_busy) begin if (wc0 == 0) s0.byte_busy <= 1'b0; else wc0 <= wc0 - 1; end
      if (!s1.byte_busy && s1.byte_start) begin s1.byte_busy <= 1'b1; wc1 <= 1; end
      else if (s1.byte_busy) begin if (wc1 == 0) s1.byte_busy <= 1'b0; else wc1 <= wc1 - 1; end
      if (!s2.byte_busy && s2.byte_start) begin s2.byte_busy <= 1'b1; wc2 <= 1; end
      else if (s2.byte_busy) begin if (wc2 == 0) s2.byte_busy <= 1'b0; else wc2 <= wc2 - 1; end
    end
  end

  // Monitors
  logic [7:0] q0[$], q1[$], q2[$];
  int done0 = 0, done1 = 0, done2 = 0;
  int stab_err = 0, ovl_err = 0;
  bit act0 = 0, seen_hi0 = 0;
  logic [7:0] cur0 = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      act0 = 0;
      seen_hi0 = 0;
    end else begin
      if (act0 && s0.byte_data !== cur0) stab_err++;
      if (s0.byte_start && s0.byte_busy) ovl_err++;
      if (s0.byte_start) begin
        act0 = 1; seen_hi0 = 0; cur0 = s0.byte_data;
        q0.push_back(s0.byte_data);
      end else if (act0) begin
        if (s0.byte_busy) seen_hi0 = 1;
        else if (seen_hi0) act0 = 0;
      end
      if (s0.frame_done) done0++;
      if (s1.byte_start) q1.push_back(s1.byte_data);
      if (s1.frame_done) done1++;
      if (s2.byte_start) q2.push_back(s2.byte_data);
      if (s2.frame_done) done2++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_frame_busy"}, 32'(s0.frame_busy), 0);
    chk({tag, "_frame_done"}, 32'(s0.frame_done), 0);
    chk({tag, "_pixel_addr"}, 32'(s0.pixel_addr), 0);
    chk({tag, "_byte_start"}, 32'(s0.byte_start), 0);
    chk({tag, "_byte_data"},  32'(s0.byte_data), 0);
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin @(negedge clk); #1; end
  endtask

  // Entered and left at negedge+1
  task automatic run_frame(input vec_t v, input string tag);
    int base, dbase, cyc;
    busy_len0 = v.busy_len;
    base  = q0.size();
    dbase = done0;
    s0.brightness  = v.bright;
    s0.frame_start = 1'b1;
    @(negedge clk); #1;
    s0.frame_start = 1'b0;
    cyc = 0;
    while (done0 == dbase && cyc < 20000) begin
      @(negedge clk); #1;
      cyc++;
      if (cyc == 4) chk({tag, "_busy_during_frame"}, 32'(s0.frame_busy), 1);
      if (cyc == 25) begin s0.brightness = v.bright_mid; s0.frame_start = 1'b1; end
      else if (cyc == 26) s0.frame_start = 1'b0;
    end
    chk({tag, "_done_seen"}, 32'(done0 - dbase), 1);
    // frame_start during DONE must be ignored
    s0.frame_start = 1'b1;
    @(negedge clk); #1;
    s0.frame_start = 1'b0;
    wait_cycles(80);
    chk({tag, "_byte_count"}, 32'(q0.size() - base), 16);
    chk({tag, "_done_count"}, 32'(done0 - dbase), 1);
    chk({tag, "_busy_after"}, 32'(s0.frame_busy), 0);
    for (int i = 0; i < 16; i++) begin
      logic [7:0] got;
      got = (q0.size() > base + i) ? q0[base + i] : 8'hxx;
      chk($sformatf("%s_byte%0d", tag, i), 32'(got), 32'(v.exp[127 - 8*i -: 8]));
    end
  endtask

  function automatic logic [7:0] big_exp(input int i, input int n);
    int k, j;
    if (i < 4) return 8'h00;
    if (i >= 4 + 4*n) return 8'hFF;
    k = (i - 4) / 4;
    j = (i - 4) % 4;
    case (j)
      0:       return 8'hE9;
      1:       return 8'hFF - 8'(k);
      2:       return 8'(k) ^ 8'h5A;
      default: return 8'(k);
    endcase
  endfunction

  initial begin
    int cyc, base;
    vecs[0] = '{5'd31, 5'd31, 3,  128'h00000000_FF332211_FFCCBBAA_FFFFFFFF};
    vecs[1] = '{5'd5,  5'd20, 2,  128'h00000000_E5332211_E5CCBBAA_FFFFFFFF};
    vecs[2] = '{5'd0,  5'd31, 50, 128'h00000000_E0332211_E0CCBBAA_FFFFFFFF};
    vecs[3] = '{5'd17, 5'd3,  1,  128'h00000000_F1332211_F1CCBBAA_FFFFFFFF};

    s0.frame_start = 1'b0; s0.brightness = '0;
    s1.frame_start = 1'b0; s1.brightness = 5'd9;
    s2.frame_start = 1'b0; s2.brightness = 5'd9;
    rst = 1'b1;
    wait_cycles(5);
    chk_idle_outputs("reset");
    rst = 1'b0;
    wait_cycles(2);

    // Long strips: 40 LEDs (4 end bytes) and 100 LEDs (7 end bytes)
    s1.frame_start = 1'b1; s2.frame_start = 1'b1;
    @(negedge clk); #1;
    s1.frame_start = 1'b0; s2.frame_start = 1'b0;
    cyc = 0;
    while ((done1 == 0 || done2 == 0) && cyc < 20000) begin
      @(negedge clk); #1; cyc++;
    end
    wait_cycles(20);
    chk("big40_done", 32'(done1), 1);
    chk("big100_done", 32'(done2), 1);
    chk("big40_bytes", 32'(q1.size()), 168);
    chk("big100_bytes", 32'(q2.size()), 411);
    for (int i = 0; i < 168 && i < q1.size(); i++)
      chk($sformatf("big40_byte%0d", i), 32'(q1[i]), 32'(big_exp(i, 40)));
    for (int i = 0; i < 411 && i < q2.size(); i++)
      chk($sformatf("big100_byte%0d", i), 32'(q2[i]), 32'(big_exp(i, 100)));

    // Table-driven frames on the 2-LED strip
    for (int t = 0; t < 4; t++) run_frame(vecs[t], $sformatf("vec%0d", t));
    chk("data_stable", 32'(stab_err), 0);
    chk("no_start_while_busy", 32'(ovl_err), 0);

    // Reset during the second pixel group
    busy_len0 = 3;
    base = q0.size();
    s0.brightness = 5'd31;
    s0.frame_start = 1'b1;
    @(negedge clk); #1;
    s0.frame_start = 1'b0;
    cyc = 0;
    while (q0.size() < base + 10 && cyc < 5000) begin
      @(negedge clk); #1; cyc++;
    end
    chk("midreset_reached", 32'(q0.size() - base), 10);
    chk("midreset_addr_before", 32'(s0.pixel_addr), 1);
    rst = 1'b1;
    @(negedge clk); #1;
    chk_idle_outputs("midreset");
    rst = 1'b0;
    wait_cycles(2);
    chk_idle_outputs("after_reset");
    run_frame(vecs[0], "post_reset");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
